// File: rtl/sched_pkg.sv
// Shared types and helpers for the kernel-launch block scheduler.
package sched_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} top_state_t;

   typedef enum logic [1:0] {RSTC, FREE, ACTIVE} slot_state_t;

   function automatic logic [31:0] ceil_div(input logic [31:0] n,
                                            input logic [31:0] d);
      return (n + d - 32'd1) / d;
   endfunction

endpackage

// File: rtl/core_slot.sv
// Per-core slot FSM: holds one block's id and thread count while the core
// works on it, and reports the core's completion to the parent.
module core_slot
   import sched_pkg::*;
#(
   parameter int ID_W  = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             grant,
   input  logic             core_done,
   input  logic             kill,
   input  logic             free_all,
   input  logic [ID_W-1:0]  id_in,
   input  logic [CNT_W-1:0] cnt_in,
   output logic             is_free,
   output logic             done_pulse,
   output logic             core_start,
   output logic             core_reset,
   output logic [ID_W-1:0]  block_id,
   output logic [CNT_W-1:0] thread_count
);

   slot_state_t      state_q, state_d;
   logic [ID_W-1:0]  id_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FREE;
         id_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            id_q  <= id_in;
            cnt_q <= cnt_in;
         end
      end
   end

   // kill wins over the kernel-end release
   always_comb begin
      state_d = state_q;
      if (kill) begin
         state_d = RSTC;
      end else if (free_all) begin
         state_d = FREE;
      end else begin
         unique case (state_q)
            RSTC:    state_d = FREE;
            FREE:    if (grant) state_d = ACTIVE;
            ACTIVE:  if (core_done) state_d = RSTC;
            default: state_d = FREE;
         endcase
      end
   end

   always_comb begin
      is_free      = (state_q == FREE);
      done_pulse   = (state_q == ACTIVE) && core_done;
      core_start   = (state_q == ACTIVE);
      core_reset   = (state_q == RSTC);
      block_id     = (state_q == ACTIVE) ? id_q  : '0;
      thread_count = (state_q == ACTIVE) ? cnt_q : '0;
   end

endmodule

// File: rtl/block_scheduler.sv
// Kernel-launch scheduler: splits a kernel into blocks and hands each one
// to the lowest-indexed free core until every block has completed.
module block_scheduler
   import sched_pkg::*;
#(
   parameter int NUM_CORES         = 2,
   parameter int THREADS_PER_BLOCK = 4,
   parameter int THREAD_COUNT_BITS = 8,
   parameter int BLOCK_ID_BITS     = 8,
   parameter int CYCLE_BITS        = 32
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                abort,
   input  logic [THREAD_COUNT_BITS-1:0]        thread_count,
   input  logic [NUM_CORES-1:0]                core_done,
   output logic [NUM_CORES-1:0]                core_start,
   output logic [NUM_CORES-1:0]                core_reset,
   output logic [NUM_CORES*BLOCK_ID_BITS-1:0]  core_block_id,
   output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0] core_thread_count,
   output logic                                busy,
   output logic                                done,
   output logic [CYCLE_BITS-1:0]               cycle_count
);

   localparam int LOG_TPB = $clog2(THREADS_PER_BLOCK);
   localparam int TW      = LOG_TPB + 1;
   localparam int CW      = (THREAD_COUNT_BITS > BLOCK_ID_BITS ?
                             THREAD_COUNT_BITS : BLOCK_ID_BITS) + 1;
   localparam int LW      = CW + LOG_TPB;

   top_state_t                   state_q, state_d;
   logic [THREAD_COUNT_BITS-1:0] n_q;
   logic [CW-1:0]                total_q, disp_q, comp_q;
   logic [CW-1:0]                pop, comp_nx;
   logic [CYCLE_BITS-1:0]        cc_q;
   logic [NUM_CORES-1:0]         grant, free_v, done_v;
   logic [LW-1:0]                rem;
   logic [TW-1:0]                cnt_nx;
   logic                         start_acc, fin, kill, free_all;
   logic                         can_disp, hit;

   assign start_acc = start && (state_q == IDLE || state_q == DONE);
   assign kill      = start_acc || (state_q == RUN && abort);
   assign fin       = (state_q == RUN) && (comp_nx == total_q);
   assign free_all  = fin && !abort;
   assign comp_nx   = comp_q + pop;
   assign can_disp  = (state_q == RUN) && !abort && !fin &&
                      (disp_q < total_q);

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_CORES; i++)
         pop = pop + CW'(done_v[i]);
   end

   always_comb begin
      grant = '0;
      hit   = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!hit && free_v[i] && can_disp) begin
            grant[i] = 1'b1;
            hit      = 1'b1;
         end
      end
   end

   // the last block may be partial; rem is at least 1 while blocks remain
   always_comb begin
      rem    = LW'(n_q) - (LW'(disp_q) << LOG_TPB);
      cnt_nx = (rem >= LW'(THREADS_PER_BLOCK)) ?
               TW'(THREADS_PER_BLOCK) : rem[TW-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE:
            if (start) state_d = (thread_count == '0) ? DONE : RUN;
         RUN:
            if (abort)    state_d = IDLE;
            else if (fin) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q == RUN);
      done        = (state_q == DONE);
      cycle_count = cc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         n_q     <= '0;
         total_q <= '0;
         disp_q  <= '0;
         comp_q  <= '0;
         cc_q    <= '0;
      end else if (start_acc) begin
         n_q     <= thread_count;
         total_q <= CW'(ceil_div(32'(thread_count),
                                 32'(THREADS_PER_BLOCK)));
         disp_q  <= '0;
         comp_q  <= '0;
         cc_q    <= '0;
      end else if (state_q == RUN) begin
         if (|grant) disp_q <= disp_q + CW'(1);
         comp_q <= comp_nx;
         if (cc_q != '1) cc_q <= cc_q + CYCLE_BITS'(1);
      end
   end

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
      core_slot #(
         .ID_W  (BLOCK_ID_BITS),
         .CNT_W (TW)
      ) u_slot (
         .clk          (clk),
         .reset        (reset),
         .grant        (grant[i]),
         .core_done    (core_done[i]),
         .kill         (kill),
         .free_all     (free_all),
         .id_in        (disp_q[BLOCK_ID_BITS-1:0]),
         .cnt_in       (cnt_nx),
         .is_free      (free_v[i]),
         .done_pulse   (done_v[i]),
         .core_start   (core_start[i]),
         .core_reset   (core_reset[i]),
         .block_id     (core_block_id[i*BLOCK_ID_BITS +: BLOCK_ID_BITS]),
         .thread_count (core_thread_count[i*TW +: TW])
      );
   end

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler with 2 cores and 4 threads per block.
module tb_block_scheduler;

   logic        clk = 1'b0;
   logic        reset, start, abort;
   logic [7:0]  thread_count;
   logic [1:0]  core_done;
   logic [1:0]  core_start, core_reset;
   logic [15:0] core_block_id;
   logic [5:0]  core_thread_count;
   logic        busy, done;
   logic [31:0] cycle_count;

   int total = 0;
   int bad   = 0;

   block_scheduler dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .abort             (abort),
      .thread_count      (thread_count),
      .core_done         (core_done),
      .core_start        (core_start),
      .core_reset        (core_reset),
      .core_block_id     (core_block_id),
      .core_thread_count (core_thread_count),
      .busy              (busy),
      .done              (done),
      .cycle_count       (cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [7:0]  tc;
      logic [1:0]  cd;
      logic [1:0]  e_start;
      logic [1:0]  e_rst;
      logic        ck_rst;
      logic        e_busy;
      logic        e_done;
      logic [15:0] e_bid;
      logic [5:0]  e_tcnt;
      logic [31:0] e_cc;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      start        = 1'b0;
      abort        = 1'b0;
      core_done    = 2'b00;
   endtask

   initial begin
      // N=10: blocks 0,1 then block 2 (2 threads) on the first freed core
      vt[0]  = '{1, 10, 2'b00, 2'b00, 2'b11, 1, 1, 0, 16'h0000, 0,  0};
      vt[1]  = '{0, 10, 2'b00, 2'b00, 2'b00, 1, 1, 0, 16'h0000, 0,  1};
      vt[2]  = '{0, 0,  2'b00, 2'b01, 2'b00, 1, 1, 0, 16'h0000, 4,  2};
      vt[3]  = '{0, 0,  2'b00, 2'b11, 2'b00, 1, 1, 0, 16'h0100, 36, 3};
      vt[4]  = '{0, 0,  2'b01, 2'b10, 2'b01, 1, 1, 0, 16'h0100, 32, 4};
      vt[5]  = '{0, 0,  2'b00, 2'b10, 2'b00, 1, 1, 0, 16'h0100, 32, 5};
      vt[6]  = '{0, 0,  2'b00, 2'b11, 2'b00, 1, 1, 0, 16'h0102, 34, 6};
      vt[7]  = '{0, 0,  2'b10, 2'b01, 2'b10, 1, 1, 0, 16'h0002, 2,  7};
      vt[8]  = '{0, 0,  2'b00, 2'b01, 2'b00, 1, 1, 0, 16'h0002, 2,  8};
      vt[9]  = '{0, 0,  2'b01, 2'b00, 2'b00, 0, 0, 1, 16'h0000, 0,  9};
      vt[10] = '{0, 0,  2'b00, 2'b00, 2'b00, 1, 0, 1, 16'h0000, 0,  9};
      vt[11] = '{0, 0,  2'b10, 2'b00, 2'b00, 1, 0, 1, 16'h0000, 0,  9};

      reset        = 1'b1;
      thread_count = 8'd0;
      idle_in();
      cyc();
      cyc();
      chk("rst_start", core_start, 0);
      chk("rst_reset", core_reset, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bid", core_block_id, 0);
      chk("rst_cc", cycle_count, 0);
      reset = 1'b0;
      cyc();

      for (int i = 0; i < 12; i++) begin
         start        = vt[i].st;
         thread_count = vt[i].tc;
         core_done    = vt[i].cd;
         cyc();
         chk($sformatf("v%0d_start", i), core_start, vt[i].e_start);
         if (vt[i].ck_rst)
            chk($sformatf("v%0d_reset", i), core_reset, vt[i].e_rst);
         chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
         chk($sformatf("v%0d_done", i), done, vt[i].e_done);
         chk($sformatf("v%0d_bid", i), core_block_id, vt[i].e_bid);
         chk($sformatf("v%0d_tcnt", i), core_thread_count, vt[i].e_tcnt);
         chk($sformatf("v%0d_cc", i), cycle_count, vt[i].e_cc);
      end
      idle_in();

      // N=0: straight to DONE, reset pulse only
      start        = 1'b1;
      thread_count = 8'd0;
      cyc();
      start = 1'b0;
      chk("n0_done", done, 1);
      chk("n0_busy", busy, 0);
      chk("n0_reset", core_reset, 2'b11);
      chk("n0_cc", cycle_count, 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("n0_nostart", core_start, 0);
      end
      chk("n0_reset_end", core_reset, 0);
      chk("n0_done_hold", done, 1);
      chk("n0_cc_hold", cycle_count, 0);

      // N=16 with simultaneous completions
      start        = 1'b1;
      thread_count = 8'd16;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      cyc();
      chk("s16_start", core_start, 2'b11);
      chk("s16_bid", core_block_id, 16'h0100);
      core_done = 2'b11;
      cyc();
      core_done = 2'b00;
      chk("s16_rst2", core_reset, 2'b11);
      chk("s16_off2", core_start, 2'b00);
      cyc();
      chk("s16_free", core_reset | core_start, 0);
      cyc();
      chk("s16_b2", core_start, 2'b01);
      chk("s16_b2id", core_block_id, 16'h0002);
      cyc();
      chk("s16_b3", core_start, 2'b11);
      chk("s16_b3id", core_block_id, 16'h0302);
      chk("s16_b3cnt", core_thread_count, 36);
      chk("s16_notdone", done, 0);
      core_done = 2'b11;
      cyc();
      core_done = 2'b00;
      chk("s16_done", done, 1);
      chk("s16_busy", busy, 0);
      chk("s16_off", core_start, 0);
      chk("s16_cc", cycle_count, 8);

      // abort two cycles after the first dispatch
      start        = 1'b1;
      thread_count = 8'd16;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      cyc();
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("ab_reset", core_reset, 2'b11);
      chk("ab_start", core_start, 2'b00);
      chk("ab_busy", busy, 0);
      chk("ab_done", done, 0);
      cyc();
      chk("ab_reset1", core_reset, 2'b00);
      chk("ab_idle", busy | done, 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("ab_relaunch", busy, 1);
      cyc();
      cyc();
      chk("ab_re_start", core_start, 2'b01);
      chk("ab_re_bid", core_block_id, 16'h0000);
      chk("ab_re_cnt", core_thread_count, 4);

      // reset mid-kernel
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("mr_start", core_start, 0);
      chk("mr_reset", core_reset, 0);
      chk("mr_busy", busy, 0);
      chk("mr_bid", core_block_id, 0);
      chk("mr_cnt", core_thread_count, 0);
      chk("mr_cc", cycle_count, 0);

      // start during RUN must not relatch N (N=6: blocks of 4 and 2)
      start        = 1'b1;
      thread_count = 8'd6;
      cyc();
      thread_count = 8'd16;
      cyc();
      start = 1'b0;
      cyc();
      chk("ig_b0", core_start, 2'b01);
      chk("ig_b0cnt", core_thread_count, 4);
      cyc();
      chk("ig_b1", core_start, 2'b11);
      chk("ig_b1bid", core_block_id, 16'h0100);
      chk("ig_b1cnt", core_thread_count, 20);
      core_done = 2'b11;
      cyc();
      core_done = 2'b00;
      chk("ig_done", done, 1);
      chk("ig_busy", busy, 0);
      cyc();
      chk("ig_nomore", core_start, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
